xadc_drp_scanner: RTL and testbench

XADC_DRP_SCANNER -- requirements
Module: xadc_drp_scanner

---
 rtl/xadc_pkg.sv | 17 +
 rtl/xadc_drp_scanner.sv | 130 +++++++++++++
 tb/tb_xadc_drp_scanner.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_pkg.sv
// Shared constants and FSM encoding for the XADC DRP round-robin scanner.
package xadc_pkg;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned SAMPLE_W = 12;

    localparam logic [6:0] DEF_ADDR0 = 7'h1E;
    localparam logic [6:0] DEF_ADDR1 = 7'h17;
    localparam logic [6:0] DEF_ADDR2 = 7'h1F;
    localparam logic [6:0] DEF_ADDR3 = 7'h16;

    typedef enum logic {
        StIdle    = 1'b0,
        StWaitRdy = 1'b1
    } state_t;

endpackage

// File: rtl/xadc_drp_scanner.sv
// Issues one DRP read per XADC end-of-conversion, rotating through four channel
// slots, and keeps the latest 12-bit result of each slot.
module xadc_drp_scanner
    import xadc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [6:0]  ADDR0          = DEF_ADDR0,
    parameter logic [6:0]  ADDR1          = DEF_ADDR1,
    parameter logic [6:0]  ADDR2          = DEF_ADDR2,
    parameter logic [6:0]  ADDR3          = DEF_ADDR3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                eoc_in,
    input  logic                drdy_in,
    input  logic [15:0]         do_in,
    output logic                den_out,
    output logic [6:0]          daddr_out,
    output logic                sample_valid,
    output logic [1:0]          sample_ch,
    output logic [SAMPLE_W-1:0] data0,
    output logic [SAMPLE_W-1:0] data1,
    output logic [SAMPLE_W-1:0] data2,
    output logic [SAMPLE_W-1:0] data3,
    output logic                timeout_err
);

    localparam int unsigned CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t              r_state;
    state_t              w_state_d;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_d;
    logic                r_den;
    logic                r_valid;
    logic [1:0]          r_ch;
    logic [6:0]          r_daddr;
    logic                r_terr;
    logic [SAMPLE_W-1:0] r_data [NUM_CH];

    logic w_start;
    logic w_capture;
    logic w_timeout;

    function automatic logic [6:0] addr_of(input logic [1:0] idx);
        case (idx)
            2'd0:    addr_of = ADDR0;
            2'd1:    addr_of = ADDR1;
            2'd2:    addr_of = ADDR2;
            default: addr_of = ADDR3;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // drdy_in takes priority over an expiring timeout on the same cycle.
    always_comb begin
        w_start   = (r_state == StIdle) && eoc_in;
        w_capture = (r_state == StWaitRdy) && drdy_in;
        w_timeout = (r_state == StWaitRdy) && !drdy_in && (r_cnt == CNT_MAX);
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (w_start) w_state_d = StWaitRdy;
            StWaitRdy: if (w_capture || w_timeout) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_idx_d = r_idx;
        w_cnt_d = r_cnt;
        if (w_capture || w_timeout) begin
            w_idx_d = r_idx + 2'd1;
        end
        if (w_start) begin
            w_cnt_d = '0;
        end else if (r_state == StWaitRdy && !w_capture && !w_timeout) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_den   <= 1'b0;
            r_valid <= 1'b0;
            r_ch    <= 2'd0;
            r_daddr <= ADDR0;
            r_terr  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_idx   <= w_idx_d;
            r_cnt   <= w_cnt_d;
            r_den   <= w_start;
            r_valid <= w_capture;
            r_daddr <= addr_of(w_idx_d);
            if (w_capture) begin
                r_ch          <= r_idx;
                r_data[r_idx] <= do_in[15:4];
            end
            if (w_timeout) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign den_out      = r_den;
    assign daddr_out    = r_daddr;
    assign sample_valid = r_valid;
    assign sample_ch    = r_ch;
    assign timeout_err  = r_terr;
    assign data0        = r_data[0];
    assign data1        = r_data[1];
    assign data2        = r_data[2];
    assign data3        = r_data[3];

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// Randomized self-checking bench for xadc_drp_scanner against a slot-level
// model (current slot, latest sample per slot, sticky error flag).
module tb_xadc_drp_scanner;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eoc_in = 1'b0;
    logic        drdy_in = 1'b0;
    logic [15:0] do_in = 16'h0;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] data0, data1, data2, data3;
    logic        timeout_err;

    logic [11:0] dut_data [4];
    assign dut_data[0] = data0;
    assign dut_data[1] = data1;
    assign dut_data[2] = data2;
    assign dut_data[3] = data3;

    xadc_drp_scanner #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .eoc_in      (eoc_in),
        .drdy_in     (drdy_in),
        .do_in       (do_in),
        .den_out     (den_out),
        .daddr_out   (daddr_out),
        .sample_valid(sample_valid),
        .sample_ch   (sample_ch),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model
    logic [6:0]  addr_tbl [4];
    logic [11:0] m_data [4];
    int          m_idx;
    bit          m_terr;

    task automatic tick();
        @(posedge clk);
        cycle++;
        #1;
    endtask

    task automatic model_reset();
        m_idx  = 0;
        m_terr = 0;
        for (int j = 0; j < 4; j++) m_data[j] = 12'h0;
    endtask

    // One eoc-triggered read; drdy arrives on WAIT cycle 'delay' (none if delay > TO).
    task automatic run_read(input int delay, input logic [15:0] dval, input bit eoc_noise,
                            input string tag);
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        n_checks++;
        if (den_out !== 1'b1 || daddr_out !== addr_tbl[m_idx] || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s issue: den=%b daddr=%h valid=%b, required den=1 daddr=%h valid=0",
                     tag, den_out, daddr_out, sample_valid, addr_tbl[m_idx]);
        end
        for (int i = 0; i <= TO; i++) begin
            if (i == delay) begin
                drdy_in = 1'b1;
                do_in   = dval;
            end else begin
                drdy_in = 1'b0;
                do_in   = 16'($urandom);
                eoc_in  = eoc_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            tick();
            drdy_in = 1'b0;
            eoc_in  = 1'b0;
            if (i == delay) begin
                int ch = m_idx;
                m_data[m_idx] = dval[15:4];
                m_idx = (m_idx + 1) % 4;
                n_checks++;
                if (sample_valid !== 1'b1 || sample_ch !== 2'(ch) || timeout_err !== m_terr ||
                    daddr_out !== addr_tbl[m_idx] || den_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s capture: valid=%b ch=%0d terr=%b daddr=%h den=%b, required valid=1 ch=%0d terr=%b daddr=%h den=0",
                             tag, sample_valid, sample_ch, timeout_err, daddr_out, den_out,
                             ch, m_terr, addr_tbl[m_idx]);
                end
                break;
            end else if (i == TO) begin
                m_terr = 1;
                m_idx  = (m_idx + 1) % 4;
                n_checks++;
                if (sample_valid !== 1'b0 || timeout_err !== 1'b1 ||
                    daddr_out !== addr_tbl[m_idx] || den_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s timeout: valid=%b terr=%b daddr=%h den=%b, required valid=0 terr=1 daddr=%h den=0",
                             tag, sample_valid, timeout_err, daddr_out, den_out, addr_tbl[m_idx]);
                end
            end else begin
                n_checks++;
                if (sample_valid !== 1'b0 || den_out !== 1'b0 ||
                    daddr_out !== addr_tbl[m_idx]) begin
                    n_fail++;
                    $display("FAIL %s wait[%0d]: valid=%b den=%b daddr=%h, required valid=0 den=0 daddr=%h",
                             tag, i, sample_valid, den_out, daddr_out, addr_tbl[m_idx]);
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (dut_data[j] !== m_data[j]) begin
                n_fail++;
                $display("FAIL %s data%0d: got %h, required %h", tag, j, dut_data[j], m_data[j]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        n_checks++;
        if (den_out !== 1'b0 || sample_valid !== 1'b0 || sample_ch !== 2'd0 ||
            timeout_err !== 1'b0 || daddr_out !== 7'h1E ||
            data0 !== 12'h0 || data1 !== 12'h0 || data2 !== 12'h0 || data3 !== 12'h0) begin
            n_fail++;
            $display("FAIL reset: den=%b valid=%b ch=%0d terr=%b daddr=%h d=%h/%h/%h/%h, required all zero daddr=1e",
                     den_out, sample_valid, sample_ch, timeout_err, daddr_out,
                     data0, data1, data2, data3);
        end
    endtask

    task automatic test_first_read();
        while (cycle < 10) tick();
        run_read(3, 16'hABCD, 1'b0, "first_read");
        n_checks++;
        if (data0 !== 12'hABC || daddr_out !== 7'h17) begin
            n_fail++;
            $display("FAIL first_read_abs: data0=%h daddr=%h, required abc 17", data0, daddr_out);
        end
    endtask

    task automatic test_rotation();
        // Slot 0 already consumed; five more reads cover wrap 3 -> 0.
        for (int r = 0; r < 5; r++) begin
            run_read(r, 16'($urandom), 1'b0, "rotation");
        end
    endtask

    task automatic test_idle_drdy();
        for (int k = 0; k < 4; k++) begin
            drdy_in = 1'b1;
            do_in   = 16'($urandom);
            tick();
            drdy_in = 1'b0;
            n_checks++;
            if (sample_valid !== 1'b0 || den_out !== 1'b0 || dut_data[m_idx] !== m_data[m_idx]) begin
                n_fail++;
                $display("FAIL idle_drdy: valid=%b den=%b data=%h, required valid=0 den=0 data=%h",
                         sample_valid, den_out, dut_data[m_idx], m_data[m_idx]);
            end
        end
    endtask

    task automatic test_timeout();
        run_read(TO + 10, 16'h0, 1'b0, "timeout");
        run_read(2, 16'($urandom), 1'b0, "after_timeout");
    endtask

    task automatic test_back_to_back_edge();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        run_read(TO, 16'h5A5A, 1'b1, "drdy_at_timeout");
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drdy_at_timeout_err: terr=%b, required 0", timeout_err);
        end
        run_read(TO - 1, 16'($urandom), 1'b1, "drdy_before_timeout");
    endtask

    task automatic test_rst_mid_wait();
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drdy_in = 1'b1;
        do_in   = 16'hFFFF;
        tick();
        drdy_in = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (sample_valid !== 1'b0 || den_out !== 1'b0 || timeout_err !== 1'b0 ||
                sample_ch !== 2'd0 || daddr_out !== 7'h1E || data0 !== 12'h0 ||
                data1 !== 12'h0 || data2 !== 12'h0 || data3 !== 12'h0) begin
                n_fail++;
                $display("FAIL rst_mid_wait[%0d]: valid=%b den=%b terr=%b ch=%0d daddr=%h d=%h/%h/%h/%h, required reset values",
                         k, sample_valid, den_out, timeout_err, sample_ch, daddr_out,
                         data0, data1, data2, data3);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                drdy_in = 1'($urandom_range(0, 1));
                do_in   = 16'($urandom);
                tick();
                drdy_in = 1'b0;
                n_checks++;
                if (sample_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_idle: valid=%b, required 0", sample_valid);
                end
            end
            run_read($urandom_range(0, 12), 16'($urandom), 1'b1, "random");
        end
    endtask

    initial begin
        addr_tbl[0] = 7'h1E;
        addr_tbl[1] = 7'h17;
        addr_tbl[2] = 7'h1F;
        addr_tbl[3] = 7'h16;
        model_reset();
        test_reset();
        test_first_read();
        test_rotation();
        test_idle_drdy();
        test_timeout();
        test_back_to_back_edge();
        test_rst_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
